// File: rtl/ring_slot_pkg.sv
// Shared types and constants for the ring slot tracker.
package ring_slot_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StTracking = 2'd1,
    StError    = 2'd2
  } tracker_state_e;

  localparam logic [1:0] ERR_NONE         = 2'b00;
  localparam logic [1:0] ERR_NOT_ONE_HOT  = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL_STEP = 2'b10;

  localparam int unsigned DEFAULT_WIDTH     = 32;
  localparam int unsigned DEFAULT_REV_WIDTH = 16;

endpackage

// File: rtl/one_hot_to_index_encoder.sv
// Combinational one-hot to binary encoder with a popcount==1 check.
module one_hot_to_index_encoder #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned INDEX_WIDTH = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]       one_hot,
  output logic [INDEX_WIDTH-1:0] index,
  output logic                   is_one_hot
);

  // OR of set-bit positions; only meaningful when is_one_hot is true.
  always_comb begin
    index = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (one_hot[i]) index = index | INDEX_WIDTH'(i);
    end
  end

  assign is_one_hot = (one_hot != '0) && ((one_hot & (one_hot - WIDTH'(1))) == '0);

endmodule

// File: rtl/ring_slot_tracker.sv
// Tracks a ring counter's one-hot phase as a registered slot index with
// advance/wrap pulses, saturating revolution count and a sticky error.
module ring_slot_tracker
  import ring_slot_pkg::*;
#(
  parameter int unsigned WIDTH       = DEFAULT_WIDTH,
  parameter int unsigned INDEX_WIDTH = $clog2(WIDTH),
  parameter int unsigned REV_WIDTH   = DEFAULT_REV_WIDTH
) (
  input  logic                   Clk_In,
  input  logic                   Reset_N_In,
  input  logic                   Enable_In,
  input  logic                   Clear_In,
  input  logic                   Running_Flag_In,
  input  logic [WIDTH-1:0]       One_Hot_In,
  output logic [INDEX_WIDTH-1:0] Slot_Index_Out,
  output logic                   Slot_Valid_Out,
  output logic                   Advance_Pulse_Out,
  output logic                   Wrap_Pulse_Out,
  output logic [REV_WIDTH-1:0]   Revolution_Count_Out,
  output logic                   Error_Flag_Out,
  output logic [1:0]             Error_Code_Out
);

  tracker_state_e         state;
  logic [INDEX_WIDTH-1:0] enc_index;
  logic                   enc_valid;
  logic [INDEX_WIDTH-1:0] next_index;

  one_hot_to_index_encoder #(
    .WIDTH      (WIDTH),
    .INDEX_WIDTH(INDEX_WIDTH)
  ) u_encoder (
    .one_hot   (One_Hot_In),
    .index     (enc_index),
    .is_one_hot(enc_valid)
  );

  // WIDTH is a power of two, so the natural rollover is the mod-WIDTH step.
  assign next_index = Slot_Index_Out + INDEX_WIDTH'(1);

  always_ff @(posedge Clk_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      state                <= StIdle;
      Slot_Index_Out       <= '0;
      Slot_Valid_Out       <= 1'b0;
      Advance_Pulse_Out    <= 1'b0;
      Wrap_Pulse_Out       <= 1'b0;
      Revolution_Count_Out <= '0;
      Error_Flag_Out       <= 1'b0;
      Error_Code_Out       <= ERR_NONE;
    end else if (Clear_In) begin
      state                <= StIdle;
      Slot_Index_Out       <= '0;
      Slot_Valid_Out       <= 1'b0;
      Advance_Pulse_Out    <= 1'b0;
      Wrap_Pulse_Out       <= 1'b0;
      Revolution_Count_Out <= '0;
      Error_Flag_Out       <= 1'b0;
      Error_Code_Out       <= ERR_NONE;
    end else if (!Enable_In) begin
      Advance_Pulse_Out <= 1'b0;
      Wrap_Pulse_Out    <= 1'b0;
    end else begin
      Advance_Pulse_Out <= 1'b0;
      Wrap_Pulse_Out    <= 1'b0;
      case (state)
        StIdle: begin
          if (enc_valid) begin
            state          <= StTracking;
            Slot_Index_Out <= enc_index;
            Slot_Valid_Out <= 1'b1;
          end
        end
        StTracking: begin
          if (!enc_valid) begin
            state          <= StError;
            Slot_Valid_Out <= 1'b0;
            Error_Flag_Out <= 1'b1;
            Error_Code_Out <= ERR_NOT_ONE_HOT;
          end else if (enc_index == next_index) begin
            Slot_Index_Out    <= enc_index;
            Advance_Pulse_Out <= 1'b1;
            if (Slot_Index_Out == '1) begin
              Wrap_Pulse_Out <= 1'b1;
              if (Revolution_Count_Out != '1) begin
                Revolution_Count_Out <= Revolution_Count_Out + REV_WIDTH'(1);
              end
            end
          end else if (enc_index != Slot_Index_Out) begin
            state          <= StError;
            Slot_Valid_Out <= 1'b0;
            Error_Flag_Out <= 1'b1;
            Error_Code_Out <= ERR_ILLEGAL_STEP;
          end
        end
        StError: begin
          // Sticky until Clear_In or reset.
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ring_slot_tracker.sv
// Self-checking bench: directed phases plus random ring traffic against a
// behavioural model; a second instance uses a 2-bit revolution counter.
module tb_ring_slot_tracker;

  localparam int W = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic        clr = 1'b0;
  logic        run = 1'b1;
  logic [31:0] oh = 32'h4;

  logic [4:0]  idx_a, idx_b;
  logic        val_a, val_b, adv_a, adv_b, wrp_a, wrp_b, err_a, err_b;
  logic [15:0] rev_a;
  logic [1:0]  rev_b;
  logic [1:0]  code_a, code_b;

  int tests = 0;
  int fails = 0;

  // Model: 0 idle, 1 tracking, 2 error.
  int m_state = 0, m_idx = 0, m_rev = 0, m_code = 0, m_adv = 0, m_wrap = 0;
  int ptr = 0;

  always #5 clk = ~clk;

  ring_slot_tracker #(.WIDTH(32), .REV_WIDTH(16)) dut_a (
    .Clk_In(clk), .Reset_N_In(rst_n), .Enable_In(en), .Clear_In(clr),
    .Running_Flag_In(run), .One_Hot_In(oh), .Slot_Index_Out(idx_a),
    .Slot_Valid_Out(val_a), .Advance_Pulse_Out(adv_a), .Wrap_Pulse_Out(wrp_a),
    .Revolution_Count_Out(rev_a), .Error_Flag_Out(err_a), .Error_Code_Out(code_a)
  );

  ring_slot_tracker #(.WIDTH(32), .REV_WIDTH(2)) dut_b (
    .Clk_In(clk), .Reset_N_In(rst_n), .Enable_In(en), .Clear_In(clr),
    .Running_Flag_In(run), .One_Hot_In(oh), .Slot_Index_Out(idx_b),
    .Slot_Valid_Out(val_b), .Advance_Pulse_Out(adv_b), .Wrap_Pulse_Out(wrp_b),
    .Revolution_Count_Out(rev_b), .Error_Flag_Out(err_b), .Error_Code_Out(code_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_idx = 0; m_rev = 0; m_code = 0; m_adv = 0; m_wrap = 0;
  endtask

  task automatic model_edge(input logic e, input logic c, input logic [31:0] w);
    int pos;
    pos = 0;
    for (int i = 0; i < W; i++) if (w[i]) pos = i;
    m_adv = 0;
    m_wrap = 0;
    if (c) begin
      model_reset();
    end else if (e) begin
      if (m_state == 0) begin
        if ($countones(w) == 1) begin
          m_state = 1;
          m_idx = pos;
        end
      end else if (m_state == 1) begin
        if ($countones(w) != 1) begin
          m_state = 2; m_code = 1;
        end else if (pos == (m_idx + 1) % W) begin
          m_adv = 1;
          if (m_idx == W - 1) begin
            m_wrap = 1;
            m_rev++;
          end
          m_idx = pos;
        end else if (pos != m_idx) begin
          m_state = 2; m_code = 2;
        end
      end
    end
  endtask

  task automatic check_all(input string ph);
    chk({ph, ".index"}, 32'(idx_a), 32'(m_idx));
    chk({ph, ".valid"}, 32'(val_a), 32'(m_state == 1));
    chk({ph, ".advance"}, 32'(adv_a), 32'(m_adv));
    chk({ph, ".wrap"}, 32'(wrp_a), 32'(m_wrap));
    chk({ph, ".rev"}, 32'(rev_a), 32'(m_rev > 65535 ? 65535 : m_rev));
    chk({ph, ".err"}, 32'(err_a), 32'(m_state == 2));
    chk({ph, ".code"}, 32'(code_a), 32'(m_code));
    chk({ph, ".rev_sat"}, 32'(rev_b), 32'(m_rev > 3 ? 3 : m_rev));
    chk({ph, ".wrap_sat"}, 32'(wrp_b), 32'(m_wrap));
  endtask

  task automatic step(input string ph, input logic e, input logic c, input logic r,
                      input logic [31:0] w);
    en = e; clr = c; run = r; oh = w;
    @(posedge clk);
    model_edge(e, c, w);
    #1;
    check_all(ph);
  endtask

  initial begin
    // Reset held with a valid one-hot present.
    #12;
    model_reset();
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step("load", 1, 0, 1, 32'h4);

    // Full walk from slot 0 through one wrap.
    step("clr0", 1, 1, 1, 32'h1);
    for (int k = 0; k <= 32; k++) step("walk", 1, 0, 1, 32'h1 << (k % 32));

    // Walk to slot 8 and hold there with the ring stopped.
    for (int k = 1; k <= 8; k++) step("to8", 1, 0, 1, 32'h1 << k);
    for (int k = 0; k < 5; k++) step("hold", 1, 0, 0, 32'h100);

    // Advances with running flag low, then a two-bit sample.
    for (int k = 9; k <= 4 + 32; k++) step("to4", 1, 0, 0, 32'h1 << (k % 32));
    step("nothot", 1, 0, 1, 32'h30);
    step("errhold", 1, 0, 1, 32'h20);
    step("errhold", 1, 0, 1, 32'h40);
    step("clr_dis", 0, 1, 1, 32'h80);

    // Illegal step 3 -> 0, then a later bad sample keeps the first cause.
    step("ill_ld", 1, 0, 1, 32'h8);
    step("ill", 1, 0, 1, 32'h1);
    step("ill_keep", 1, 0, 1, 32'h0);
    step("clr1", 1, 1, 1, 32'h0);

    // Five revolutions with enable gaps carrying junk inputs.
    step("sat_ld", 1, 0, 1, 32'h1);
    ptr = 0;
    for (int k = 1; k <= 160; k++) begin
      if (k % 37 == 0) begin
        step("dis", 0, 0, 1, $urandom);
        step("dis", 0, 0, 0, 32'h0);
      end
      ptr = (ptr + 1) % W;
      step("sat", 1, 0, 1, 32'h1 << ptr);
    end

    // Async reset mid-operation.
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic: mostly legal advances and holds, occasional faults.
    ptr = $urandom_range(0, W - 1);
    for (int k = 0; k < 400; k++) begin
      int r;
      logic [31:0] w;
      logic e, c;
      r = $urandom_range(0, 99);
      if (r < 60) begin
        ptr = (ptr + 1) % W;
        w = 32'h1 << ptr;
      end else if (r < 78) begin
        w = 32'h1 << ptr;
      end else if (r < 83) begin
        w = $urandom;
      end else if (r < 86) begin
        w = 32'h0;
      end else if (r < 89) begin
        ptr = $urandom_range(0, W - 1);
        w = 32'h1 << ptr;
      end else if (r < 92) begin
        ptr = 0;
        w = 32'h1;
      end else begin
        w = 32'h1 << ptr;
      end
      e = ($urandom_range(0, 9) != 0);
      c = ($urandom_range(0, 24) == 0);
      step("rand", e, c, 1'($urandom), w);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
